uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_tx_buffered.sv | 149 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a power-of-two byte FIFO feeding a
// start/data/stop serialiser, with every serial bit held ClockFreq/BaudRate cycles.
module uart_tx_buffered #(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200,
  parameter int Depth     = 8
) (
  input  logic                     Clock,
  input  logic                     Reset_B,
  input  logic [7:0]               DataIn,
  input  logic                     DataInValid,
  output logic                     DataInReady,
  output logic                     SOut,
  output logic                     Busy,
  output logic [$clog2(Depth):0]   Count
);

  localparam int unsigned SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int unsigned BaudW  = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
  localparam int unsigned AddrW  = $clog2(Depth);
  localparam int unsigned CountW = AddrW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]        r_mem [Depth];
  logic [AddrW-1:0]  r_wr_ptr;
  logic [AddrW-1:0]  r_rd_ptr;
  logic [CountW-1:0] r_count;
  logic [1:0]        r_state;
  logic [BaudW-1:0]  r_baud;
  logic [2:0]        r_bit;
  logic [7:0]        r_shift;
  logic              r_sout;

  logic w_ready;
  logic w_push;
  logic w_pop;
  logic w_baud_end;

  // Ready depends on the registered occupancy only, so a full FIFO refuses
  // a push even on the cycle the serialiser pops.
  assign w_ready    = (r_count < CountW'(Depth));
  assign w_push     = DataInValid && w_ready;
  assign w_baud_end = (r_baud == BaudW'(SymbolEdgeTime - 1));
  assign w_pop      = (r_count != '0) &&
                      ((r_state == IDLE) || ((r_state == STOP) && w_baud_end));

  always_ff @(posedge Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= DataIn;
    end
  end

  always_ff @(posedge Clock or negedge Reset_B) begin
    if (!Reset_B) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AddrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AddrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CountW'(1);
        2'b01:   r_count <= r_count - CountW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_B) begin
    if (!Reset_B) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_sout  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_sout <= 1'b1;
          r_baud <= '0;
          r_bit  <= '0;
          if (w_pop) begin
            r_shift <= r_mem[r_rd_ptr];
            r_sout  <= 1'b0;
            r_state <= START;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_sout  <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == 3'd7) begin
              r_sout  <= 1'b1;
              r_state <= STOP;
            end else begin
              // Next bit is shift[1]: the register moves down as it is emitted.
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_sout  <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= r_mem[r_rd_ptr];
              r_sout  <= 1'b0;
              r_state <= START;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_baud <= r_baud + BaudW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_sout  <= 1'b1;
        end
      endcase
    end
  end

  assign DataInReady = w_ready;
  assign SOut        = r_sout;
  assign Busy        = (r_state != IDLE) || (r_count != '0);
  assign Count       = r_count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered at 4 clocks per serial bit,
// with a line-sampling receiver model fed by an expected-byte queue.
module tb_uart_tx_buffered;

  logic       Clock;
  logic       Reset_B;
  logic [7:0] DataIn;
  logic       DataInValid;
  logic       DataInReady;
  logic       SOut;
  logic       Busy;
  logic [3:0] Count;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] sb[$];

  uart_tx_buffered #(
    .ClockFreq(400),
    .BaudRate (100),
    .Depth    (8)
  ) dut (
    .Clock      (Clock),
    .Reset_B    (Reset_B),
    .DataIn     (DataIn),
    .DataInValid(DataInValid),
    .DataInReady(DataInReady),
    .SOut       (SOut),
    .Busy       (Busy),
    .Count      (Count)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((Busy !== 1'b0) && (n < budget)) begin
      @(negedge Clock);
      n++;
    end
    chk("idle_reached", Busy, 0);
  endtask

  // Receiver model: 40 line samples per frame, each bit must be stable for 4.
  logic        mon_active = 1'b0;
  int          mon_j = 0;
  logic [39:0] mon_line;
  always @(negedge Clock) begin
    logic       ok;
    logic [7:0] rx;
    logic [7:0] exp_b;
    if (Reset_B !== 1'b1) begin
      mon_active = 1'b0;
      mon_j = 0;
    end else if (!mon_active) begin
      if (SOut === 1'b0) begin
        mon_active = 1'b1;
        mon_line[0] = 1'b0;
        mon_j = 1;
      end
    end else begin
      mon_line[mon_j] = SOut;
      mon_j++;
      if (mon_j == 40) begin
        mon_active = 1'b0;
        ok = 1'b1;
        for (int b = 0; b < 10; b++)
          for (int s = 1; s < 4; s++)
            if (mon_line[b*4+s] !== mon_line[b*4]) ok = 1'b0;
        if (mon_line[36] !== 1'b1) ok = 1'b0;
        for (int i = 0; i < 8; i++) rx[i] = mon_line[(i+1)*4];
        chk("rx_framing", ok, 1);
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rx_unexpected_frame: got 0x%0h expected no frame", rx);
        end else begin
          exp_b = sb.pop_front();
          chk("rx_byte", rx, exp_b);
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] exp_line;   // transmitted order, bit 0 first
    logic [3:0] exp_count;  // occupancy right after the push edge
  } vec_t;
  vec_t tbl[7];

  initial begin
    logic [7:0] burst[10];
    int         acc_edge[10];
    int         edge_i;
    int         k;
    logic       acc;
    logic [3:0] nib;
    logic       samp[41];
    int         bad;
    int         gap;
    int         n;
    logic [7:0] b;

    tbl[0] = '{8'h55, 10'h2AA, 4'd1};
    tbl[1] = '{8'h00, 10'h200, 4'd1};
    tbl[2] = '{8'hFF, 10'h3FE, 4'd1};
    tbl[3] = '{8'hA3, 10'h346, 4'd1};
    tbl[4] = '{8'h0F, 10'h21E, 4'd1};
    tbl[5] = '{8'h80, 10'h300, 4'd1};
    tbl[6] = '{8'h01, 10'h202, 4'd1};

    // Reset with a byte offered: nothing may be taken until release.
    Reset_B = 1'b0;
    DataIn = 8'hC3;
    DataInValid = 1'b1;
    repeat (3) @(negedge Clock);
    chk("reset_sout", SOut, 1);
    chk("reset_busy", Busy, 0);
    chk("reset_count", Count, 0);
    chk("reset_ready", DataInReady, 1);
    #2 Reset_B = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    chk("first_edge_push", Count, 1);
    sb.push_back(8'hC3);
    DataInValid = 1'b0;
    wait_idle(200);
    chk("sb_drain_reset", sb.size(), 0);

    // Single bytes into an idle block, line checked bit by bit.
    for (int v = 0; v < 7; v++) begin
      @(negedge Clock);
      DataIn = tbl[v].data;
      DataInValid = 1'b1;
      @(negedge Clock);
      DataInValid = 1'b0;
      DataIn = 8'hXX;
      sb.push_back(tbl[v].data);
      chk("tbl_count", Count, tbl[v].exp_count);
      chk("tbl_latency_sout", SOut, 1);
      for (int j = 0; j < 40; j++) begin
        @(negedge Clock);
        nib[j%4] = SOut;
        if (j % 4 == 3) chk($sformatf("tbl%0d_bit%0d", v, j/4), nib, {4{tbl[v].exp_line[j/4]}});
        if (j == 0) chk("tbl_count_popped", Count, 0);
        if (j == 39) chk("tbl_busy_last", Busy, 1);
      end
      @(negedge Clock);
      chk("tbl_busy_after_40", Busy, 0);
    end
    chk("sb_drain_tbl", sb.size(), 0);

    // Ten offers on consecutive edges against an eight-entry FIFO.
    for (int i = 0; i < 10; i++) begin
      burst[i] = 8'(8'h30 + i * 7);
      acc_edge[i] = -1;
    end
    edge_i = 0;
    k = 0;
    while ((k < 10) && (edge_i < 200)) begin
      DataIn = burst[k];
      DataInValid = 1'b1;
      acc = DataInReady;
      @(posedge Clock);
      if (acc) begin
        acc_edge[k] = edge_i;
        sb.push_back(burst[k]);
        k++;
      end
      edge_i++;
      @(negedge Clock);
      if (edge_i == 9) begin
        chk("burst_count_full", Count, 8);
        chk("burst_ready_low", DataInReady, 0);
      end
      if (edge_i == 42) begin
        chk("full_pop_count", Count, 7);
        chk("full_pop_ready", DataInReady, 1);
      end
      if (edge_i == 43) chk("full_push_next", Count, 8);
    end
    DataInValid = 1'b0;
    chk("burst_done", k, 10);
    chk("burst_edge8", acc_edge[8], 8);
    chk("burst_edge9", acc_edge[9], 42);
    wait_idle(1000);
    chk("sb_drain_burst", sb.size(), 0);

    // Back-to-back frames: stop bit runs straight into the next start bit.
    @(negedge Clock);
    DataIn = 8'hA3;
    DataInValid = 1'b1;
    @(negedge Clock);
    sb.push_back(8'hA3);
    DataIn = 8'h0F;
    @(negedge Clock);
    sb.push_back(8'h0F);
    DataInValid = 1'b0;
    samp[0] = SOut;
    chk("b2b_start", SOut, 0);
    for (int j = 1; j <= 40; j++) begin
      @(negedge Clock);
      samp[j] = SOut;
    end
    chk("b2b_no_gap", {samp[39], samp[40]}, 2'b10);
    wait_idle(200);
    chk("sb_drain_b2b", sb.size(), 0);

    // Reset during data bit 3 of a zero byte, with more bytes queued.
    @(negedge Clock);
    DataIn = 8'h00;
    DataInValid = 1'b1;
    @(negedge Clock);
    DataIn = 8'h12;
    @(negedge Clock);
    DataIn = 8'h34;
    @(negedge Clock);
    DataInValid = 1'b0;
    repeat (15) @(negedge Clock);
    chk("pre_reset_bit3_low", SOut, 0);
    #2 Reset_B = 1'b0;
    sb.delete();
    #1;
    chk("midreset_sout", SOut, 1);
    chk("midreset_count", Count, 0);
    chk("midreset_busy", Busy, 0);
    repeat (2) @(negedge Clock);
    Reset_B = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge Clock);
      if ((SOut !== 1'b1) || (Busy !== 1'b0)) bad++;
    end
    chk("post_reset_quiet", bad, 0);

    // Random bytes with random gaps; garbage on DataIn while not valid.
    for (int i = 0; i < 200; i++) begin
      gap = ($urandom_range(0, 7) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 3));
      DataInValid = 1'b0;
      repeat (gap) begin
        DataIn = 8'($urandom);
        @(negedge Clock);
      end
      b = 8'($urandom);
      DataIn = b;
      DataInValid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && (n < 200)) begin
        acc = DataInReady;
        @(posedge Clock);
        if (acc) sb.push_back(b);
        @(negedge Clock);
        n++;
      end
      chk("rand_accept", acc, 1);
    end
    DataInValid = 1'b0;
    wait_idle(1000);
    chk("sb_drain_rand", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
